// File: rtl/control_unit_if.sv
// Bus bundle between the control unit and the datapath / memories it steers.
// The master side is the control unit; the slave side is the datapath and memories.
interface control_unit_if;
   logic [6:0]  PC_Addr;
   logic [15:0] IR_in;
   logic [15:0] IR_out;
   logic [3:0]  State;
   logic        zero_flag;
   logic [7:0]  D_Addr;
   logic        D_Wr;
   logic        RF_s;
   logic [3:0]  RF_W_Addr;
   logic [3:0]  RF_Ra_Addr;
   logic [3:0]  RF_Rb_Addr;
   logic        RF_W_en;
   logic [2:0]  ALU_s0;

   modport master (
      input  IR_in, zero_flag,
      output PC_Addr, IR_out, State, D_Addr, D_Wr, RF_s,
             RF_W_Addr, RF_Ra_Addr, RF_Rb_Addr, RF_W_en, ALU_s0
   );

   modport slave (
      output IR_in, zero_flag,
      input  PC_Addr, IR_out, State, D_Addr, D_Wr, RF_s,
             RF_W_Addr, RF_Ra_Addr, RF_Rb_Addr, RF_W_en, ALU_s0
   );
endinterface

// File: rtl/control_unit.sv
// Multi-cycle control FSM: fetch, decode and execute for a small 16-bit ISA,
// driving Moore-style datapath controls from the current state and instruction register.
module control_unit (
   input  logic           Clock,
   input  logic           rst,
   control_unit_if.master bus
);
   typedef enum logic [3:0] {
      S_INIT   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_NOOP   = 4'd3,
      S_LOAD_A = 4'd4,
      S_LOAD_B = 4'd5,
      S_STORE  = 4'd6,
      S_ADD_A  = 4'd7,
      S_ADD_B  = 4'd8,
      S_SUB_A  = 4'd9,
      S_SUB_B  = 4'd10,
      S_HALT   = 4'd11,
      S_JZ     = 4'd12
   } state_e;

   localparam logic [3:0] OP_STORE = 4'h1;
   localparam logic [3:0] OP_LOAD  = 4'h2;
   localparam logic [3:0] OP_ADD   = 4'h3;
   localparam logic [3:0] OP_SUB   = 4'h4;
   localparam logic [3:0] OP_HALT  = 4'h5;
   localparam logic [3:0] OP_JZ    = 4'h6;

   localparam logic [2:0] ALU_ADD  = 3'b001;
   localparam logic [2:0] ALU_SUB  = 3'b010;

   state_e      state_q, state_d;
   logic [6:0]  pc_q, pc_d;
   logic [15:0] ir_q, ir_d;

   logic [7:0]  d_addr_s;
   logic        d_wr_s;
   logic        rf_s_s;
   logic [3:0]  rf_w_addr_s;
   logic [3:0]  rf_ra_addr_s;
   logic [3:0]  rf_rb_addr_s;
   logic        rf_w_en_s;
   logic [2:0]  alu_s0_s;

   // Unknown opcodes fall through to the NOOP execute state.
   function automatic state_e decode_op(input logic [3:0] op);
      case (op)
         OP_STORE: decode_op = S_STORE;
         OP_LOAD:  decode_op = S_LOAD_A;
         OP_ADD:   decode_op = S_ADD_A;
         OP_SUB:   decode_op = S_SUB_A;
         OP_HALT:  decode_op = S_HALT;
         OP_JZ:    decode_op = S_JZ;
         default:  decode_op = S_NOOP;
      endcase
   endfunction

   always_ff @(posedge Clock) begin
      if (rst) begin
         state_q <= S_INIT;
         pc_q    <= 7'd0;
         ir_q    <= 16'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
      end
   end

   always_comb begin
      state_d = S_INIT;
      pc_d    = pc_q;
      ir_d    = ir_q;
      case (state_q)
         S_INIT:   state_d = S_FETCH;
         S_FETCH: begin
            state_d = S_DECODE;
            pc_d    = pc_q + 7'd1;
         end
         S_DECODE: begin
            state_d = decode_op(bus.IR_in[15:12]);
            ir_d    = bus.IR_in;
         end
         S_LOAD_A: state_d = S_LOAD_B;
         S_ADD_A:  state_d = S_ADD_B;
         S_SUB_A:  state_d = S_SUB_B;
         S_NOOP, S_LOAD_B, S_STORE, S_ADD_B, S_SUB_B: state_d = S_FETCH;
         S_JZ: begin
            state_d = S_FETCH;
            if (bus.zero_flag) begin
               pc_d = ir_q[6:0];
            end else begin
               pc_d = pc_q;
            end
         end
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_INIT;
      endcase
   end

   // The B half of ADD/SUB holds the ALU op so the registered ALU result is written back.
   always_comb begin
      d_addr_s     = 8'd0;
      d_wr_s       = 1'b0;
      rf_s_s       = 1'b0;
      rf_w_addr_s  = 4'd0;
      rf_ra_addr_s = 4'd0;
      rf_rb_addr_s = 4'd0;
      rf_w_en_s    = 1'b0;
      alu_s0_s     = 3'b000;
      case (state_q)
         S_LOAD_A: d_addr_s = ir_q[11:4];
         S_LOAD_B: begin
            d_addr_s    = ir_q[11:4];
            rf_s_s      = 1'b1;
            rf_w_addr_s = ir_q[3:0];
            rf_w_en_s   = 1'b1;
         end
         S_STORE: begin
            d_addr_s     = ir_q[11:4];
            rf_ra_addr_s = ir_q[3:0];
            d_wr_s       = 1'b1;
         end
         S_ADD_A, S_SUB_A: begin
            rf_ra_addr_s = ir_q[11:8];
            rf_rb_addr_s = ir_q[7:4];
            alu_s0_s     = (state_q == S_ADD_A) ? ALU_ADD : ALU_SUB;
         end
         S_ADD_B, S_SUB_B: begin
            rf_ra_addr_s = ir_q[11:8];
            rf_rb_addr_s = ir_q[7:4];
            rf_w_addr_s  = ir_q[3:0];
            rf_w_en_s    = 1'b1;
            alu_s0_s     = (state_q == S_ADD_B) ? ALU_ADD : ALU_SUB;
         end
         default: begin
            d_addr_s = 8'd0;
         end
      endcase
   end

   assign bus.PC_Addr    = pc_q;
   assign bus.IR_out     = ir_q;
   assign bus.State      = state_q;
   assign bus.D_Addr     = d_addr_s;
   assign bus.RF_s       = rf_s_s;
   assign bus.RF_W_Addr  = rf_w_addr_s;
   assign bus.RF_Ra_Addr = rf_ra_addr_s;
   assign bus.RF_Rb_Addr = rf_rb_addr_s;
   assign bus.ALU_s0     = alu_s0_s;
   // Reset aborts any write strobe within the same cycle.
   assign bus.D_Wr       = d_wr_s & ~rst;
   assign bus.RF_W_en    = rf_w_en_s & ~rst;
endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: an instruction-level reference model
// expands each fetched word into its expected per-cycle outputs.
module tb_control_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   bit   zf  = 1'b0;

   control_unit_if bus();
   control_unit dut (.Clock(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   logic [15:0] mem [0:127];
   always @(posedge clk) bus.IR_in <= mem[bus.PC_Addr];

   typedef struct packed {
      logic [3:0] st;
      logic [7:0] da;
      logic       dw;
      logic       rs;
      logic [3:0] wa;
      logic [3:0] ra;
      logic [3:0] rb;
      logic       we;
      logic [2:0] alu;
   } rec_t;

   rec_t        q[$];
   logic [6:0]  pc_m;
   logic [15:0] ir_m;
   logic [15:0] cur_w;
   bit          valid = 1'b0;
   int          checks = 0;
   int          passes = 0;

   function automatic rec_t mk(input logic [3:0] st);
      rec_t r;
      r = '0;
      r.st = st;
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   // Expand the instruction at pc_m into the cycles it must produce.
   task automatic gen();
      rec_t r;
      cur_w = mem[pc_m];
      q.push_back(mk(4'd1));
      q.push_back(mk(4'd2));
      case (cur_w[15:12])
         4'h1: begin
            r = mk(4'd6); r.da = cur_w[11:4]; r.ra = cur_w[3:0]; r.dw = 1'b1;
            q.push_back(r);
         end
         4'h2: begin
            r = mk(4'd4); r.da = cur_w[11:4];
            q.push_back(r);
            r.st = 4'd5; r.rs = 1'b1; r.wa = cur_w[3:0]; r.we = 1'b1;
            q.push_back(r);
         end
         4'h3, 4'h4: begin
            r = mk((cur_w[15:12] == 4'h3) ? 4'd7 : 4'd9);
            r.ra = cur_w[11:8]; r.rb = cur_w[7:4];
            r.alu = (cur_w[15:12] == 4'h3) ? 3'd1 : 3'd2;
            q.push_back(r);
            r.st = r.st + 4'd1; r.wa = cur_w[3:0]; r.we = 1'b1;
            q.push_back(r);
         end
         4'h5:    q.push_back(mk(4'd11));
         4'h6:    q.push_back(mk(4'd12));
         default: q.push_back(mk(4'd3));
      endcase
   endtask

   task automatic model_edge();
      rec_t r;
      if (rst) begin
         q.delete();
         q.push_back(mk(4'd0));
         pc_m  = 7'd0;
         ir_m  = 16'd0;
         valid = 1'b1;
      end else if (valid) begin
         r = q.pop_front();
         if (r.st == 4'd1) pc_m = pc_m + 7'd1;
         if (r.st == 4'd2) ir_m = cur_w;
         if (r.st == 4'd12 && zf) pc_m = cur_w[6:0];
         if (r.st == 4'd11) q.push_back(r);
         if (q.size() == 0) gen();
      end
   endtask

   task automatic tick(input bit r, input bit z);
      rec_t e;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      rst = r;
      zf  = z;
      bus.zero_flag = z;
      #1;
      if (valid) begin
         e = q[0];
         check("cycle",
            64'({bus.State, bus.PC_Addr, bus.IR_out, bus.D_Addr, bus.D_Wr, bus.RF_s,
                 bus.RF_W_Addr, bus.RF_Ra_Addr, bus.RF_Rb_Addr, bus.RF_W_en, bus.ALU_s0}),
            64'({e.st, pc_m, ir_m, e.da, e.dw & ~rst, e.rs,
                 e.wa, e.ra, e.rb, e.we & ~rst, e.alu}));
      end
   endtask

   task automatic run_until(input logic [3:0] st, input bit z, input int budget);
      int n = 0;
      while (q[0].st != st && n < budget) begin
         tick(1'b0, z);
         n++;
      end
      check("reach_state", 64'(q[0].st), 64'(st));
   endtask

   task automatic do_reset(input logic [15:0] w0);
      tick(1'b1, 1'b0);
      mem[0] = w0;
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
   endtask

   initial begin
      bus.zero_flag = 1'b0;
      for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
      mem[1]     = 16'h3124;
      mem[2]     = 16'h4124;
      mem[3]     = 16'h10A7;
      mem[4]     = 16'h6015;
      mem[7'h15] = 16'h6015;
      mem[7'h16] = 16'hF000;
      mem[7'h17] = 16'h607F;
      mem[7'h7F] = 16'h0000;

      // LOAD 16'h2053 straight out of reset
      do_reset(16'h2053);
      check("rst_state", 64'(bus.State), 64'(4'd0));
      check("rst_outs", 64'({bus.PC_Addr, bus.IR_out, bus.D_Addr, bus.D_Wr, bus.RF_s, bus.RF_W_Addr,
                            bus.RF_Ra_Addr, bus.RF_Rb_Addr, bus.RF_W_en, bus.ALU_s0}), 64'(0));
      tick(1'b0, 1'b0);
      check("first_fetch", 64'(bus.State), 64'(4'd1));
      tick(1'b0, 1'b0);
      check("decode", 64'(bus.State), 64'(4'd2));
      tick(1'b0, 1'b0);
      check("load_a", 64'({bus.State, bus.D_Addr, bus.RF_W_en, bus.D_Wr}), 64'({4'd4, 8'h05, 1'b0, 1'b0}));
      tick(1'b0, 1'b0);
      check("load_b", 64'({bus.State, bus.D_Addr, bus.RF_s, bus.RF_W_en, bus.RF_W_Addr}),
            64'({4'd5, 8'h05, 1'b1, 1'b1, 4'd3}));
      tick(1'b0, 1'b0);
      check("load_pc", 64'({bus.State, bus.PC_Addr}), 64'({4'd1, 7'd1}));

      run_until(4'd7, 1'b0, 20);
      check("add_a", 64'({bus.RF_Ra_Addr, bus.RF_Rb_Addr, bus.ALU_s0, bus.RF_W_en}), 64'({4'd1, 4'd2, 3'b001, 1'b0}));
      tick(1'b0, 1'b0);
      check("add_b", 64'({bus.State, bus.ALU_s0, bus.RF_W_en, bus.RF_s, bus.RF_W_Addr}),
            64'({4'd8, 3'b001, 1'b1, 1'b0, 4'd4}));
      run_until(4'd9, 1'b0, 20);
      check("sub_a", 64'({bus.ALU_s0, bus.RF_W_en}), 64'({3'b010, 1'b0}));
      tick(1'b0, 1'b0);
      check("sub_b", 64'({bus.State, bus.ALU_s0, bus.RF_W_en}), 64'({4'd10, 3'b010, 1'b1}));

      run_until(4'd6, 1'b0, 20);
      check("store", 64'({bus.D_Addr, bus.RF_Ra_Addr, bus.D_Wr, bus.RF_W_en}), 64'({8'h0A, 4'd7, 1'b1, 1'b0}));
      tick(1'b0, 1'b0);
      check("store_end", 64'({bus.State, bus.D_Wr}), 64'({4'd1, 1'b0}));

      run_until(4'd12, 1'b1, 20);
      tick(1'b0, 1'b1);
      check("jz_taken", 64'({bus.State, bus.PC_Addr}), 64'({4'd1, 7'h15}));
      run_until(4'd12, 1'b0, 20);
      tick(1'b0, 1'b0);
      check("jz_not_taken", 64'({bus.State, bus.PC_Addr}), 64'({4'd1, 7'h16}));
      run_until(4'd3, 1'b0, 20);
      check("op_f_noop", 64'({bus.State, bus.IR_out}), 64'({4'd3, 16'hF000}));
      run_until(4'd12, 1'b1, 20);
      tick(1'b0, 1'b1);
      check("jz_to_127", 64'(bus.PC_Addr), 64'(7'h7F));
      tick(1'b0, 1'b1);
      check("pc_wrap", 64'({bus.State, bus.PC_Addr}), 64'({4'd2, 7'd0}));

      // HALT holds with frozen PC and no strobes
      do_reset(16'h5000);
      run_until(4'd11, 1'b0, 20);
      for (int i = 0; i < 20; i++) begin
         tick(1'b0, i[0]);
         check("halt_hold", 64'({bus.State, bus.PC_Addr, bus.D_Wr, bus.RF_W_en}), 64'({4'd11, 7'd1, 1'b0, 1'b0}));
      end

      // Reset landing in LOAD_B aborts the register write
      do_reset(16'h2053);
      run_until(4'd4, 1'b0, 20);
      tick(1'b1, 1'b0);
      check("abort_load_b", 64'({bus.State, bus.RF_W_en}), 64'({4'd5, 1'b0}));
      tick(1'b0, 1'b0);
      check("abort_init", 64'({bus.State, bus.PC_Addr}), 64'({4'd0, 7'd0}));

      // Random programs, zero flag and occasional resets
      for (int i = 0; i < 128; i++) begin
         mem[i] = 16'($urandom);
         if (mem[i][15:12] == 4'h5 && $urandom_range(0, 3) != 0) mem[i][15:12] = 4'h3;
      end
      do_reset(mem[0]);
      for (int i = 0; i < 3000; i++) begin
         tick(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
